// File: rtl/two_output_demux_buffer_if.sv
// Stream bundle for the 1-to-2 demux buffer: one valid/ready input, two valid/ready outputs.
interface two_output_demux_buffer_if #(
    parameter int unsigned width = 16
);
    logic             S;
    logic             In_Valid;
    logic [width-1:0] In_Data;
    logic             In_Ready;
    logic             Out1_Valid;
    logic [width-1:0] Out1_Data;
    logic             Out1_Ready;
    logic             Out2_Valid;
    logic [width-1:0] Out2_Data;
    logic             Out2_Ready;

    // Producer/consumer side (drives input word and output readies)
    modport master (
        output S, In_Valid, In_Data, Out1_Ready, Out2_Ready,
        input  In_Ready, Out1_Valid, Out1_Data, Out2_Valid, Out2_Data
    );

    // Demux buffer side
    modport slave (
        input  S, In_Valid, In_Data, Out1_Ready, Out2_Ready,
        output In_Ready, Out1_Valid, Out1_Data, Out2_Valid, Out2_Data
    );
endinterface

// File: rtl/two_output_demux_buffer.sv
// Registered 1-to-2 stream demultiplexer. Each output port owns a 2-entry FIFO so a
// stalled consumer never blocks traffic headed to the other port.
module two_output_demux_buffer #(
    parameter int unsigned width = 16
) (
    input logic                    Clk,
    input logic                    Reset_n,
    two_output_demux_buffer_if.slave bus
);
    // Index 0 is port 1, index 1 is port 2.
    logic [1:0][1:0][width-1:0] mem_q, mem_d;
    logic [1:0]                 wptr_q, wptr_d;
    logic [1:0]                 rptr_q, rptr_d;
    logic [1:0][1:0]            cnt_q, cnt_d;
    logic [1:0]                 push, pop;
    logic [1:0]                 out_ready;
    logic                       in_ready;

    assign out_ready = {bus.Out2_Ready, bus.Out1_Ready};

    // Input ready looks only at the selected FIFO's registered count; a pop in the
    // same cycle does not free a slot early.
    always_comb begin
        in_ready = bus.S ? (cnt_q[1] != 2'd2) : (cnt_q[0] != 2'd2);
    end

    // Next-state for both FIFOs: push on accept to the selected port, pop on handshake.
    always_comb begin
        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        push   = '0;
        pop    = '0;
        for (int p = 0; p < 2; p++) begin
            push[p] = bus.In_Valid && in_ready && (bus.S == p[0]);
            pop[p]  = (cnt_q[p] != 2'd0) && out_ready[p];
            if (push[p]) begin
                mem_d[p][wptr_q[p]] = bus.In_Data;
                wptr_d[p]           = ~wptr_q[p];
            end
            if (pop[p]) begin
                rptr_d[p] = ~rptr_q[p];
            end
            if (push[p] && !pop[p]) begin
                cnt_d[p] = cnt_q[p] + 2'd1;
            end else if (pop[p] && !push[p]) begin
                cnt_d[p] = cnt_q[p] - 2'd1;
            end
        end
    end

    // State registers; async reset clears storage too so outputs read 0 after reset.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            mem_q  <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            mem_q  <= mem_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    assign bus.In_Ready   = in_ready;
    assign bus.Out1_Valid = (cnt_q[0] != 2'd0);
    assign bus.Out1_Data  = mem_q[0][rptr_q[0]];
    assign bus.Out2_Valid = (cnt_q[1] != 2'd0);
    assign bus.Out2_Data  = mem_q[1][rptr_q[1]];
endmodule

// File: tb/tb_two_output_demux_buffer.sv
// Self-checking bench for two_output_demux_buffer: directed scenarios plus randomized
// traffic checked against a queue-based model of the two per-port FIFOs.
module tb_two_output_demux_buffer;
    logic Clk = 1'b0;
    logic Reset_n;

    always #5 Clk = ~Clk;

    two_output_demux_buffer_if #(.width(16)) bus ();

    two_output_demux_buffer #(.width(16)) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: one FIFO queue per port, capacity 2.
    logic [15:0] q1[$];
    logic [15:0] q2[$];
    logic        rdy_seen;

    // Apply one cycle of stimulus (entered at posedge+1), sample In_Ready before the
    // edge, then advance the model by the handshakes that occur on that edge.
    task automatic drive(input logic s, input logic v, input logic [15:0] d,
                         input logic r1, input logic r2);
        logic acc, p1, p2;
        bus.S          = s;
        bus.In_Valid   = v;
        bus.In_Data    = d;
        bus.Out1_Ready = r1;
        bus.Out2_Ready = r2;
        #1;
        rdy_seen = bus.In_Ready;
        acc = v && ((s ? q2.size() : q1.size()) != 2);
        p1  = (q1.size() != 0) && r1;
        p2  = (q2.size() != 0) && r2;
        @(posedge Clk);
        #1;
        if (p1) void'(q1.pop_front());
        if (p2) void'(q2.pop_front());
        if (acc) begin
            if (s) q2.push_back(d);
            else   q1.push_back(d);
        end
    endtask

    task automatic test_reset();
        Reset_n        = 1'b0;
        bus.S          = 1'b0;
        bus.In_Valid   = 1'b0;
        bus.In_Data    = '0;
        bus.Out1_Ready = 1'b0;
        bus.Out2_Ready = 1'b0;
        #12;
        vectors++;
        if (bus.Out1_Valid !== 1'b0 || bus.Out2_Valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_valid got v1=%b v2=%b want 0 0", bus.Out1_Valid, bus.Out2_Valid);
        end
        vectors++;
        if (bus.Out1_Data !== 16'h0 || bus.Out2_Data !== 16'h0) begin
            miscompares++;
            $display("FAIL reset_data got d1=%h d2=%h want 0000 0000", bus.Out1_Data, bus.Out2_Data);
        end
        vectors++;
        if (bus.In_Ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_in_ready got %b want 1", bus.In_Ready);
        end
        q1.delete();
        q2.delete();
        @(negedge Clk);
        Reset_n = 1'b1;
        @(posedge Clk);
        #1;
    endtask

    task automatic test_basic();
        drive(1'b0, 1'b1, 16'h1111, 1'b1, 1'b1);
        vectors++;
        if (rdy_seen !== 1'b1 || bus.Out1_Valid !== 1'b1 || bus.Out1_Data !== 16'h1111) begin
            miscompares++;
            $display("FAIL basic_port1 got rdy=%b v=%b d=%h want 1 1 1111",
                     rdy_seen, bus.Out1_Valid, bus.Out1_Data);
        end
        drive(1'b1, 1'b1, 16'h2222, 1'b1, 1'b1);
        vectors++;
        if (rdy_seen !== 1'b1 || bus.Out2_Valid !== 1'b1 || bus.Out2_Data !== 16'h2222 ||
            bus.Out1_Valid !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_port2 got rdy=%b v2=%b d2=%h v1=%b want 1 1 2222 0",
                     rdy_seen, bus.Out2_Valid, bus.Out2_Data, bus.Out1_Valid);
        end
        drive(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
    endtask

    task automatic test_full_stall();
        drive(1'b0, 1'b1, 16'hA001, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 16'hA002, 1'b0, 1'b0);
        vectors++;
        if (rdy_seen !== 1'b1) begin
            miscompares++;
            $display("FAIL stall_second_accept got rdy=%b want 1", rdy_seen);
        end
        drive(1'b0, 1'b1, 16'hA003, 1'b0, 1'b0);
        vectors++;
        if (rdy_seen !== 1'b0 || bus.Out1_Data !== 16'hA001) begin
            miscompares++;
            $display("FAIL stall_full got rdy=%b d1=%h want 0 a001", rdy_seen, bus.Out1_Data);
        end
    endtask

    task automatic test_cross_port();
        drive(1'b1, 1'b1, 16'hB0B0, 1'b0, 1'b0);
        vectors++;
        if (rdy_seen !== 1'b1 || bus.Out2_Valid !== 1'b1 || bus.Out2_Data !== 16'hB0B0 ||
            bus.Out1_Data !== 16'hA001) begin
            miscompares++;
            $display("FAIL cross_port got rdy=%b v2=%b d2=%h d1=%h want 1 1 b0b0 a001",
                     rdy_seen, bus.Out2_Valid, bus.Out2_Data, bus.Out1_Data);
        end
        // Pop while full: no bypass, A003 is still refused this cycle.
        drive(1'b0, 1'b1, 16'hA003, 1'b1, 1'b1);
        vectors++;
        if (rdy_seen !== 1'b0 || bus.Out1_Data !== 16'hA002 || bus.Out2_Valid !== 1'b0) begin
            miscompares++;
            $display("FAIL full_pop_no_bypass got rdy=%b d1=%h v2=%b want 0 a002 0",
                     rdy_seen, bus.Out1_Data, bus.Out2_Valid);
        end
        drive(1'b0, 1'b1, 16'hA003, 1'b1, 1'b0);
        vectors++;
        if (rdy_seen !== 1'b1 || bus.Out1_Valid !== 1'b1 || bus.Out1_Data !== 16'hA003) begin
            miscompares++;
            $display("FAIL stall_release got rdy=%b v1=%b d1=%h want 1 1 a003",
                     rdy_seen, bus.Out1_Valid, bus.Out1_Data);
        end
        drive(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
        vectors++;
        if (bus.Out1_Valid !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_drained got v1=%b want 0", bus.Out1_Valid);
        end
    endtask

    task automatic test_push_pop_same();
        drive(1'b1, 1'b1, 16'hC001, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 16'hC002, 1'b0, 1'b1);
        vectors++;
        if (rdy_seen !== 1'b1 || bus.Out2_Valid !== 1'b1 || bus.Out2_Data !== 16'hC002) begin
            miscompares++;
            $display("FAIL push_pop_head got rdy=%b v2=%b d2=%h want 1 1 c002",
                     rdy_seen, bus.Out2_Valid, bus.Out2_Data);
        end
        drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
        vectors++;
        if (bus.Out2_Valid !== 1'b0) begin
            miscompares++;
            $display("FAIL push_pop_count got v2=%b want 0 (count should have been 1)",
                     bus.Out2_Valid);
        end
    endtask

    task automatic test_s_toggle();
        int refused;
        drive(1'b0, 1'b1, 16'hD001, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 16'hD002, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 16'hE001, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 16'hE002, 1'b0, 1'b0);
        refused = 0;
        for (int i = 0; i < 4; i++) begin
            drive(i[0], 1'b1, 16'hF00F, 1'b0, 1'b0);
            if (rdy_seen === 1'b0) refused++;
        end
        vectors++;
        if (refused != 4) begin
            miscompares++;
            $display("FAIL toggle_refused got %0d refusals want 4", refused);
        end
        // Free port 2 while S points at full port 1, then select port 2.
        drive(1'b0, 1'b1, 16'hF00F, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 16'hF00F, 1'b0, 1'b0);
        vectors++;
        if (rdy_seen !== 1'b1 || bus.Out1_Data !== 16'hD001 || bus.Out2_Data !== 16'hE002) begin
            miscompares++;
            $display("FAIL toggle_accept got rdy=%b d1=%h d2=%h want 1 d001 e002",
                     rdy_seen, bus.Out1_Data, bus.Out2_Data);
        end
        drive(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
        vectors++;
        if (bus.Out1_Data !== 16'hD002 || bus.Out2_Data !== 16'hF00F) begin
            miscompares++;
            $display("FAIL toggle_route got d1=%h d2=%h want d002 f00f",
                     bus.Out1_Data, bus.Out2_Data);
        end
        drive(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
        vectors++;
        if (bus.Out1_Valid !== 1'b0 || bus.Out2_Valid !== 1'b0) begin
            miscompares++;
            $display("FAIL toggle_drain got v1=%b v2=%b want 0 0 (word duplicated)",
                     bus.Out1_Valid, bus.Out2_Valid);
        end
    endtask

    task automatic test_async_reset();
        drive(1'b0, 1'b1, 16'h1234, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 16'h5678, 1'b0, 1'b0);
        bus.S        = 1'b0;
        bus.In_Valid = 1'b0;
        #2;
        Reset_n = 1'b0;
        #1;
        vectors++;
        if (bus.Out1_Valid !== 1'b0 || bus.Out2_Valid !== 1'b0 || bus.In_Ready !== 1'b1 ||
            bus.Out1_Data !== 16'h0 || bus.Out2_Data !== 16'h0) begin
            miscompares++;
            $display("FAIL async_reset got v1=%b v2=%b rdy=%b d1=%h d2=%h want 0 0 1 0000 0000",
                     bus.Out1_Valid, bus.Out2_Valid, bus.In_Ready, bus.Out1_Data, bus.Out2_Data);
        end
        q1.delete();
        q2.delete();
        @(negedge Clk);
        Reset_n = 1'b1;
        @(posedge Clk);
        #1;
        drive(1'b1, 1'b1, 16'h5A5A, 1'b0, 1'b0);
        vectors++;
        if (bus.Out2_Valid !== 1'b1 || bus.Out2_Data !== 16'h5A5A || bus.Out1_Valid !== 1'b0) begin
            miscompares++;
            $display("FAIL after_reset got v2=%b d2=%h v1=%b want 1 5a5a 0",
                     bus.Out2_Valid, bus.Out2_Data, bus.Out1_Valid);
        end
        drive(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
    endtask

    task automatic test_random();
        logic        s, v, r1, r2, exp_rdy;
        logic [15:0] d;
        for (int n = 0; n < 400; n++) begin
            s       = 1'($urandom_range(0, 1));
            v       = ($urandom_range(0, 3) != 0);
            d       = 16'($urandom);
            r1      = ($urandom_range(0, 2) != 0);
            r2      = ($urandom_range(0, 2) != 0);
            exp_rdy = ((s ? q2.size() : q1.size()) != 2);
            drive(s, v, d, r1, r2);
            vectors++;
            if (rdy_seen !== exp_rdy) begin
                miscompares++;
                $display("FAIL rand_in_ready cycle %0d got %b want %b", n, rdy_seen, exp_rdy);
            end
            vectors++;
            if (bus.Out1_Valid !== (q1.size() != 0) ||
                (q1.size() != 0 && bus.Out1_Data !== q1[0])) begin
                miscompares++;
                $display("FAIL rand_port1 cycle %0d got v=%b d=%h want v=%b d=%h", n,
                         bus.Out1_Valid, bus.Out1_Data, (q1.size() != 0),
                         (q1.size() != 0) ? q1[0] : 16'h0);
            end
            vectors++;
            if (bus.Out2_Valid !== (q2.size() != 0) ||
                (q2.size() != 0 && bus.Out2_Data !== q2[0])) begin
                miscompares++;
                $display("FAIL rand_port2 cycle %0d got v=%b d=%h want v=%b d=%h", n,
                         bus.Out2_Valid, bus.Out2_Data, (q2.size() != 0),
                         (q2.size() != 0) ? q2[0] : 16'h0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full_stall();
        test_cross_port();
        test_push_pop_same();
        test_s_toggle();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
